regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 91 +++++++++
 tb/tb_regfile_scoreboard.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - writeback, read and issue bundle for regfile_scoreboard
//
// Groups every non-clock, non-reset signal of the register file / scoreboard.
//   slave  : the regfile_scoreboard side (consumes WB/ID/issue, drives data/stall/busy)
//   master : the pipeline side (drives WB/ID/issue, consumes data/stall/busy)
// Signals:
//   do_writeback1, writeRegister1[4:0], writeData1[31:0]   WB stage write
//   readRegisterA1[4:0], readRegisterB1[4:0]               ID source indices
//   issue_valid1, issue_useA1, issue_useB1                 issue request / source use
//   issue_writes1, issue_dest1[4:0]                        issue destination
//   readDataA1_OUT[31:0], readDataB1_OUT[31:0]             source data (combinational)
//   stall1_OUT                                             issue blocked (combinational)
//   busy_OUT[31:0]                                         registered pending-writer map
interface regfile_scoreboard_if;
  logic        do_writeback1;
  logic [4:0]  writeRegister1;
  logic [31:0] writeData1;
  logic [4:0]  readRegisterA1;
  logic [4:0]  readRegisterB1;
  logic        issue_valid1;
  logic        issue_useA1;
  logic        issue_useB1;
  logic        issue_writes1;
  logic [4:0]  issue_dest1;
  logic [31:0] readDataA1_OUT;
  logic [31:0] readDataB1_OUT;
  logic        stall1_OUT;
  logic [31:0] busy_OUT;

  modport master (
    output do_writeback1, writeRegister1, writeData1,
    output readRegisterA1, readRegisterB1,
    output issue_valid1, issue_useA1, issue_useB1, issue_writes1, issue_dest1,
    input  readDataA1_OUT, readDataB1_OUT, stall1_OUT, busy_OUT
  );

  modport slave (
    input  do_writeback1, writeRegister1, writeData1,
    input  readRegisterA1, readRegisterB1,
    input  issue_valid1, issue_useA1, issue_useB1, issue_writes1, issue_dest1,
    output readDataA1_OUT, readDataB1_OUT, stall1_OUT, busy_OUT
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with issue scoreboard and optional WB bypass
//
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous active-high reset: clears all registers and the busy map
//   bus    regfile_scoreboard_if.slave (writeback, two read ports, issue/stall, busy map)
// Parameter:
//   BYPASS 1 = writeback data forwarded to read ports in the same cycle, 0 = no forwarding
module regfile_scoreboard #(
  parameter bit BYPASS = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  regfile_scoreboard_if.slave   bus
);

  logic [31:0] regs [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        clear_a;
  logic        clear_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        hazard_waw;
  logic        stall;
  logic        issue;

  // Read ports; register 0 is hard zero and is never forwarded.
  always_comb begin
    rd_a = 32'h0;
    if (bus.readRegisterA1 != 5'd0) begin
      if (BYPASS && bus.do_writeback1 && (bus.writeRegister1 == bus.readRegisterA1))
        rd_a = bus.writeData1;
      else
        rd_a = regs[bus.readRegisterA1];
    end
  end

  always_comb begin
    rd_b = 32'h0;
    if (bus.readRegisterB1 != 5'd0) begin
      if (BYPASS && bus.do_writeback1 && (bus.writeRegister1 == bus.readRegisterB1))
        rd_b = bus.writeData1;
      else
        rd_b = regs[bus.readRegisterB1];
    end
  end

  // A source hazard is cleared only when the pending value is being forwarded
  // this cycle; without bypass the reader waits until the register is written.
  assign clear_a  = BYPASS & bus.do_writeback1 & (bus.writeRegister1 == bus.readRegisterA1);
  assign clear_b  = BYPASS & bus.do_writeback1 & (bus.writeRegister1 == bus.readRegisterB1);
  assign hazard_a = bus.issue_useA1 & busy_q[bus.readRegisterA1] & ~clear_a;
  assign hazard_b = bus.issue_useB1 & busy_q[bus.readRegisterB1] & ~clear_b;

  // The old writer retiring this cycle frees the destination regardless of bypass,
  // since the new writer's result lands strictly later.
  assign hazard_waw = bus.issue_writes1 & busy_q[bus.issue_dest1]
                    & ~(bus.do_writeback1 & (bus.writeRegister1 == bus.issue_dest1));

  assign stall = bus.issue_valid1 & (hazard_a | hazard_b | hazard_waw);
  assign issue = bus.issue_valid1 & ~stall;

  assign set_vec = (issue && bus.issue_writes1 && (bus.issue_dest1 != 5'd0))
                 ? (32'h1 << bus.issue_dest1) : 32'h0;
  assign clr_vec = bus.do_writeback1 ? (32'h1 << bus.writeRegister1) : 32'h0;

  // Clear first, then set, so a new writer to the retiring register keeps it busy.
  assign busy_d = ((busy_q & ~clr_vec) | set_vec) & ~32'h1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      busy_q <= 32'h0;
    end else begin
      if (bus.do_writeback1 && (bus.writeRegister1 != 5'd0))
        regs[bus.writeRegister1] <= bus.writeData1;
      busy_q <= busy_d;
    end
  end

  assign bus.readDataA1_OUT = rd_a;
  assign bus.readDataB1_OUT = rd_b;
  assign bus.stall1_OUT     = stall;
  assign bus.busy_OUT       = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
//
// Two instances share one stimulus: u_dut1 with BYPASS=1, u_dut0 with BYPASS=0.
// Inputs are changed 1ns after a rising edge and outputs are sampled 1ns later.
module tb_regfile_scoreboard;

  logic        CLK;
  logic        RESET;
  logic        do_writeback1;
  logic [4:0]  writeRegister1;
  logic [31:0] writeData1;
  logic [4:0]  readRegisterA1;
  logic [4:0]  readRegisterB1;
  logic        issue_valid1;
  logic        issue_useA1;
  logic        issue_useB1;
  logic        issue_writes1;
  logic [4:0]  issue_dest1;

  int n_vec;
  int n_err;

  regfile_scoreboard_if bif1 ();
  regfile_scoreboard_if bif0 ();

  assign bif1.do_writeback1  = do_writeback1;
  assign bif1.writeRegister1 = writeRegister1;
  assign bif1.writeData1     = writeData1;
  assign bif1.readRegisterA1 = readRegisterA1;
  assign bif1.readRegisterB1 = readRegisterB1;
  assign bif1.issue_valid1   = issue_valid1;
  assign bif1.issue_useA1    = issue_useA1;
  assign bif1.issue_useB1    = issue_useB1;
  assign bif1.issue_writes1  = issue_writes1;
  assign bif1.issue_dest1    = issue_dest1;

  assign bif0.do_writeback1  = do_writeback1;
  assign bif0.writeRegister1 = writeRegister1;
  assign bif0.writeData1     = writeData1;
  assign bif0.readRegisterA1 = readRegisterA1;
  assign bif0.readRegisterB1 = readRegisterB1;
  assign bif0.issue_valid1   = issue_valid1;
  assign bif0.issue_useA1    = issue_useA1;
  assign bif0.issue_useB1    = issue_useB1;
  assign bif0.issue_writes1  = issue_writes1;
  assign bif0.issue_dest1    = issue_dest1;

  regfile_scoreboard #(.BYPASS(1'b1)) u_dut1 (.CLK(CLK), .RESET(RESET), .bus(bif1));
  regfile_scoreboard #(.BYPASS(1'b0)) u_dut0 (.CLK(CLK), .RESET(RESET), .bus(bif0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    do_writeback1  = 1'b0;
    writeRegister1 = 5'd0;
    writeData1     = 32'h0;
    readRegisterA1 = 5'd0;
    readRegisterB1 = 5'd0;
    issue_valid1   = 1'b0;
    issue_useA1    = 1'b0;
    issue_useB1    = 1'b0;
    issue_writes1  = 1'b0;
    issue_dest1    = 5'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    do_writeback1  = 1'b1;
    writeRegister1 = r;
    writeData1     = d;
  endtask

  task automatic iss_write(input logic [4:0] d);
    issue_valid1  = 1'b1;
    issue_writes1 = 1'b1;
    issue_dest1   = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;

    // First cycle after reset: nothing busy, every register reads zero.
    readRegisterA1 = 5'd5; readRegisterB1 = 5'd31;
    issue_valid1 = 1'b1; issue_useA1 = 1'b1; issue_useB1 = 1'b1;
    issue_writes1 = 1'b1; issue_dest1 = 5'd17;
    #1;
    chk("rst_busy1", u_dut1.bus.busy_OUT, 32'h0);
    chk("rst_busy0", u_dut0.bus.busy_OUT, 32'h0);
    chk("rst_stall1", {31'h0, bif1.stall1_OUT}, 32'h0);
    chk("rst_stall0", {31'h0, bif0.stall1_OUT}, 32'h0);
    chk("rst_rda", bif1.readDataA1_OUT, 32'h0);
    chk("rst_rdb", bif0.readDataB1_OUT, 32'h0);
    idle();
    tick();

    // Write r5, forwarded only with bypass, visible to both next cycle.
    wb(5'd5, 32'hDEADBEEF); readRegisterA1 = 5'd5;
    #1;
    chk("r5_fwd1", bif1.readDataA1_OUT, 32'hDEADBEEF);
    chk("r5_old0", bif0.readDataA1_OUT, 32'h0);
    tick();
    idle(); readRegisterA1 = 5'd5;
    #1;
    chk("r5_rd1", bif1.readDataA1_OUT, 32'hDEADBEEF);
    chk("r5_rd0", bif0.readDataA1_OUT, 32'hDEADBEEF);
    chk("wb_nonbusy", bif1.busy_OUT, 32'h0);

    // r0 is hard zero, including during the write.
    wb(5'd0, 32'h1234); readRegisterA1 = 5'd0; readRegisterB1 = 5'd0;
    #1;
    chk("r0_fwd1", bif1.readDataA1_OUT, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_rd1", bif1.readDataB1_OUT, 32'h0);
    chk("r0_rd0", bif0.readDataA1_OUT, 32'h0);

    // r7: old value 11111111, then same-cycle write of A5A5A5A5 on port B.
    wb(5'd7, 32'h11111111);
    tick();
    wb(5'd7, 32'hA5A5A5A5); readRegisterB1 = 5'd7;
    #1;
    chk("r7_fwd1", bif1.readDataB1_OUT, 32'hA5A5A5A5);
    chk("r7_old0", bif0.readDataB1_OUT, 32'h11111111);
    tick();
    idle(); readRegisterB1 = 5'd7;
    #1;
    chk("r7_new0", bif0.readDataB1_OUT, 32'hA5A5A5A5);
    chk("r7_new1", bif1.readDataB1_OUT, 32'hA5A5A5A5);

    // RAW on r3; the stalled instruction also writes r6 and must not mark it.
    idle(); iss_write(5'd3);
    #1;
    chk("iss3_stall", {31'h0, bif1.stall1_OUT}, 32'h0);
    tick();
    idle();
    issue_valid1 = 1'b1; issue_useA1 = 1'b1; readRegisterA1 = 5'd3;
    issue_writes1 = 1'b1; issue_dest1 = 5'd6;
    #1;
    chk("busy3_1", bif1.busy_OUT, 32'h0000_0008);
    chk("busy3_0", bif0.busy_OUT, 32'h0000_0008);
    chk("raw_stall1", {31'h0, bif1.stall1_OUT}, 32'h1);
    chk("raw_stall0", {31'h0, bif0.stall1_OUT}, 32'h1);
    tick();
    chk("stalled_noupd", bif1.busy_OUT, 32'h0000_0008);
    wb(5'd3, 32'h33);
    #1;
    chk("raw_clr_stall1", {31'h0, bif1.stall1_OUT}, 32'h0);
    chk("raw_clr_stall0", {31'h0, bif0.stall1_OUT}, 32'h1);
    chk("raw_fwd_data1", bif1.readDataA1_OUT, 32'h33);
    tick();
    idle();
    #1;
    chk("busy_after_wb1", bif1.busy_OUT, 32'h0000_0040);
    chk("busy_after_wb0", bif0.busy_OUT, 32'h0);
    wb(5'd6, 32'h66);
    tick();
    idle();
    #1;
    chk("busy6_clr", bif1.busy_OUT, 32'h0);

    // WAW on r4, then writeback r4 plus new writer r4: set wins.
    iss_write(5'd4);
    tick();
    #1;
    chk("waw_stall", {31'h0, bif0.stall1_OUT}, 32'h1);
    wb(5'd4, 32'h44);
    #1;
    chk("waw_clr_stall1", {31'h0, bif1.stall1_OUT}, 32'h0);
    chk("waw_clr_stall0", {31'h0, bif0.stall1_OUT}, 32'h0);
    tick();
    idle();
    #1;
    chk("set_wins1", bif1.busy_OUT, 32'h0000_0010);
    chk("set_wins0", bif0.busy_OUT, 32'h0000_0010);

    // Set r8 and clear r4 in one cycle.
    wb(5'd4, 32'h444); iss_write(5'd8);
    tick();
    idle();
    #1;
    chk("set_clr_diff", bif1.busy_OUT, 32'h0000_0100);

    // Issue with dest r0 never marks busy[0].
    iss_write(5'd0);
    tick();
    idle();
    #1;
    chk("busy0_zero", bif0.busy_OUT, 32'h0000_0100);

    // Build busy {2,8,9} and r2=55, then reset with a writeback and issue pending.
    wb(5'd2, 32'h55); iss_write(5'd2);
    tick();
    idle(); iss_write(5'd9);
    tick();
    idle(); readRegisterA1 = 5'd2;
    #1;
    chk("pre_rst_busy", bif1.busy_OUT, 32'h0000_0304);
    chk("pre_rst_r2", bif1.readDataA1_OUT, 32'h55);
    RESET = 1'b1;
    wb(5'd13, 32'h77); iss_write(5'd12);
    tick();
    RESET = 1'b0;
    idle();
    readRegisterA1 = 5'd2; readRegisterB1 = 5'd13;
    issue_valid1 = 1'b1; issue_useA1 = 1'b1; issue_useB1 = 1'b1;
    #1;
    chk("post_rst_busy1", bif1.busy_OUT, 32'h0);
    chk("post_rst_busy0", bif0.busy_OUT, 32'h0);
    chk("post_rst_r2", bif1.readDataA1_OUT, 32'h0);
    chk("post_rst_r13", bif0.readDataB1_OUT, 32'h0);
    readRegisterA1 = 5'd9;
    #1;
    chk("post_rst_stall1", {31'h0, bif1.stall1_OUT}, 32'h0);
    chk("post_rst_stall0", {31'h0, bif0.stall1_OUT}, 32'h0);
    idle();
    tick();
    #1;
    chk("no_deferred", bif1.busy_OUT, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
